// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, instruction opcodes
// and IR capture pattern, used by the TAP FSM and the data path.
package jtag_pkg;

    localparam int FSM_SIZE = 4;
    localparam int IR_WIDTH = 4;

    typedef logic [FSM_SIZE-1:0] tap_state_t;

    localparam tap_state_t ST_TLR   = 4'hF;
    localparam tap_state_t ST_RTI   = 4'hC;
    localparam tap_state_t ST_SELDR = 4'h7;
    localparam tap_state_t ST_CAPDR = 4'h6;
    localparam tap_state_t ST_SHDR  = 4'h2;
    localparam tap_state_t ST_EX1DR = 4'h1;
    localparam tap_state_t ST_PAUDR = 4'h3;
    localparam tap_state_t ST_EX2DR = 4'h0;
    localparam tap_state_t ST_UPDDR = 4'h5;
    localparam tap_state_t ST_SELIR = 4'h4;
    localparam tap_state_t ST_CAPIR = 4'hE;
    localparam tap_state_t ST_SHIR  = 4'hA;
    localparam tap_state_t ST_EX1IR = 4'h9;
    localparam tap_state_t ST_PAUIR = 4'hB;
    localparam tap_state_t ST_EX2IR = 4'h8;
    localparam tap_state_t ST_UPDIR = 4'hD;

    typedef logic [IR_WIDTH-1:0] opcode_t;

    localparam opcode_t OP_IDCODE  = 4'b0001;
    localparam opcode_t OP_USER    = 4'b0100;
    localparam opcode_t OP_BYPASS  = 4'b1111;
    localparam opcode_t IR_CAPTURE = 4'b0001;

endpackage

// File: rtl/jtag_shift_reg.sv
// Parallel-capture, right-shifting scan register; TDI enters the MSB
// and the LSB is the bit presented towards TDO.
module jtag_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             capture,
    input  logic             shift,
    input  logic [WIDTH-1:0] capture_val,
    input  logic             TDI,
    output logic [WIDTH-1:0] sr,
    output logic             sr_lsb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (capture) begin
            sr_d = capture_val;
        end else if (shift) begin
            sr_d = {TDI, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr     = sr_q;
    assign sr_lsb = sr_q[0];

endmodule

// File: rtl/jtag_ir_dr_path.sv
// JTAG data path behind the TAP FSM: IR, BYPASS, IDCODE and USER
// registers, TDI->TDO serial path and the USER parallel interface.
module jtag_ir_dr_path
    import jtag_pkg::*;
#(
    parameter int          FSM_SIZE   = jtag_pkg::FSM_SIZE,
    parameter int          IR_WIDTH   = jtag_pkg::IR_WIDTH,
    parameter int          USER_WIDTH = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5093
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic [FSM_SIZE-1:0]   state,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  TDO_EN,
    output logic [IR_WIDTH-1:0]   ir,
    input  logic [USER_WIDTH-1:0] user_in,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  user_upd
);

    // IEEE 1149.1 mandates a 1 in the IDCODE LSB
    if (!IDCODE_VAL[0]) begin : g_idcode_chk
        $error("IDCODE_VAL bit0 must be 1");
    end

    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [IR_WIDTH-1:0]   ir_shift;
    logic                  ir_lsb;
    logic                  bypass_q, bypass_d;
    logic                  idcode_lsb;
    logic [USER_WIDTH-1:0] user_sr;
    logic                  user_lsb;
    logic [USER_WIDTH-1:0] user_out_q, user_out_d;
    logic                  user_upd_q, user_upd_d;
    logic                  tdo_q, tdo_d;
    logic                  tdo_en_q, tdo_en_d;
    logic                  sel_idcode, sel_user, sel_bypass;
    logic                  dr_lsb;

    assign sel_idcode = (ir_q == OP_IDCODE);
    assign sel_user   = (ir_q == OP_USER);
    assign sel_bypass = !sel_idcode && !sel_user;

    jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir_sr (
        .TCK        (TCK),
        .TRST       (TRST),
        .capture    (state == ST_CAPIR),
        .shift      (state == ST_SHIR),
        .capture_val(IR_CAPTURE),
        .TDI        (TDI),
        .sr         (ir_shift),
        .sr_lsb     (ir_lsb)
    );

    jtag_shift_reg #(.WIDTH(32)) u_idcode_sr (
        .TCK        (TCK),
        .TRST       (TRST),
        .capture    ((state == ST_CAPDR) && sel_idcode),
        .shift      ((state == ST_SHDR) && sel_idcode),
        .capture_val(IDCODE_VAL),
        .TDI        (TDI),
        .sr         (),
        .sr_lsb     (idcode_lsb)
    );

    jtag_shift_reg #(.WIDTH(USER_WIDTH)) u_user_sr (
        .TCK        (TCK),
        .TRST       (TRST),
        .capture    ((state == ST_CAPDR) && sel_user),
        .shift      ((state == ST_SHDR) && sel_user),
        .capture_val(user_in),
        .TDI        (TDI),
        .sr         (user_sr),
        .sr_lsb     (user_lsb)
    );

    always_comb begin
        ir_d       = ir_q;
        bypass_d   = bypass_q;
        user_out_d = user_out_q;
        user_upd_d = 1'b0;
        if (state == ST_TLR) begin
            ir_d = OP_IDCODE;
        end else if (state == ST_UPDIR) begin
            ir_d = ir_shift;
        end
        if (sel_bypass && state == ST_CAPDR) begin
            bypass_d = 1'b0;
        end else if (sel_bypass && state == ST_SHDR) begin
            bypass_d = TDI;
        end
        if (sel_user && state == ST_UPDDR) begin
            user_out_d = user_sr;
            user_upd_d = 1'b1;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_q       <= OP_IDCODE;
            bypass_q   <= 1'b0;
            user_out_q <= '0;
            user_upd_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            bypass_q   <= bypass_d;
            user_out_q <= user_out_d;
            user_upd_q <= user_upd_d;
        end
    end

    always_comb begin
        unique case (1'b1)
            sel_idcode: dr_lsb = idcode_lsb;
            sel_user:   dr_lsb = user_lsb;
            default:    dr_lsb = bypass_q;
        endcase
    end

    // TDO keeps its last value outside shift states
    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        if (state == ST_SHIR) begin
            tdo_d    = ir_lsb;
            tdo_en_d = 1'b1;
        end else if (state == ST_SHDR) begin
            tdo_d    = dr_lsb;
            tdo_en_d = 1'b1;
        end
    end

    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign ir       = ir_q;
    assign user_out = user_out_q;
    assign user_upd = user_upd_q;
    assign TDO      = tdo_q;
    assign TDO_EN   = tdo_en_q;

endmodule
